// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared types and default widths for the 16-bit pipeline.
//                - wb_state_t : writeback FSM states (IDLE, WAIT_MEM)
//                - wb_req_t   : context held while a load waits on memory
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // Default datapath widths for the pipeline.
    localparam int c_pc_w   = 16;
    localparam int c_data_w = 16;
    localparam int c_reg_w  = 4;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } wb_state_t;

    // Everything about a load that is needed once its data returns.
    // Field widths track the pipeline defaults above.
    typedef struct packed {
        logic                wr_en;
        logic [c_reg_w-1:0]  rd;
        logic [c_pc_w-1:0]   next_pc;
    } wb_req_t;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : wb_stage
//  Description : Writeback stage. Retires instructions from EX/MEM, issuing
//                at most one register-file write (we3/wa3/wd3) per retired
//                instruction. ALU results retire one cycle after accept;
//                loads hold the stage in WAIT_MEM until mem_ack_i or until
//                TMO cycles pass, after which the load is dropped and err_o
//                latches.
//
//  Ports       :
//    clk_i, rst_i          clock, synchronous active-high reset
//    valid_i               instruction presented by EX/MEM
//    wr_en_i, is_load_i    writes a register / result comes from memory
//    rd_i, alu_res_i       destination register, ALU result
//    next_pc_i             next_pc of the instruction (trace)
//    mem_ack_i, mem_rdata_i  data-memory completion and load data
//    stall_o               upstream must hold (high while in WAIT_MEM)
//    we3, wa3, wd3         register-file write port
//    retire_o, retire_pc_o, retire_cnt_o  retire trace and count
//    err_o                 sticky load-timeout flag
//
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_stage
    import cpu_pkg::*;
#(
    parameter int P   = c_pc_w,
    parameter int D   = c_data_w,
    parameter int R   = c_reg_w,
    parameter int C   = 16,
    parameter int TMO = 15
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         valid_i,
    input  logic         wr_en_i,
    input  logic         is_load_i,
    input  logic [R-1:0] rd_i,
    input  logic [D-1:0] alu_res_i,
    input  logic [P-1:0] next_pc_i,
    input  logic         mem_ack_i,
    input  logic [D-1:0] mem_rdata_i,
    output logic         stall_o,
    output logic         we3,
    output logic [R-1:0] wa3,
    output logic [D-1:0] wd3,
    output logic         retire_o,
    output logic [P-1:0] retire_pc_o,
    output logic [C-1:0] retire_cnt_o,
    output logic         err_o
);

    // Timeout counter must hold values 0..TMO-1; keep at least one bit.
    localparam int            TW          = (TMO > 1) ? $clog2(TMO) : 1;
    localparam logic [TW-1:0] c_tmo_last  = TW'(TMO - 1);

    wb_state_t    r_state;
    wb_state_t    w_state_nxt;
    wb_req_t      r_req;
    logic [TW-1:0] r_tmo_cnt;

    logic         r_we3;
    logic [R-1:0] r_wa3;
    logic [D-1:0] r_wd3;
    logic         r_retire;
    logic [P-1:0] r_retire_pc;
    logic [C-1:0] r_retire_cnt;
    logic         r_err;

    logic         w_accept;
    logic         w_alu_retire;
    logic         w_ld_start;
    logic         w_ld_done;
    logic         w_timeout;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and event decode. Ack takes priority over timeout, so an
    // ack arriving in the final allowed cycle still completes the load.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_accept     = 1'b0;
        w_alu_retire = 1'b0;
        w_ld_start   = 1'b0;
        w_ld_done    = 1'b0;
        w_timeout    = 1'b0;

        case (r_state)
            IDLE: begin
                w_accept = valid_i;
                if (valid_i) begin
                    if (is_load_i) begin
                        w_ld_start  = 1'b1;
                        w_state_nxt = WAIT_MEM;
                    end else begin
                        w_alu_retire = 1'b1;
                    end
                end
            end
            WAIT_MEM: begin
                if (mem_ack_i) begin
                    w_ld_done   = 1'b1;
                    w_state_nxt = IDLE;
                end else if (r_tmo_cnt == c_tmo_last) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Load context and timeout counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_req     <= '0;
            r_tmo_cnt <= '0;
        end else if (w_ld_start) begin
            r_req     <= '{wr_en: wr_en_i, rd: rd_i, next_pc: next_pc_i};
            r_tmo_cnt <= '0;
        end else if (r_state == WAIT_MEM) begin
            r_tmo_cnt <= r_tmo_cnt + TW'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Register-file write port and retire trace. Strobes default low each
    // cycle; wa3/wd3 only move when a write is actually issued.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_we3        <= 1'b0;
            r_wa3        <= '0;
            r_wd3        <= '0;
            r_retire     <= 1'b0;
            r_retire_pc  <= '0;
            r_retire_cnt <= '0;
        end else begin
            r_we3    <= 1'b0;
            r_retire <= 1'b0;

            if (w_alu_retire) begin
                r_we3        <= wr_en_i;
                r_retire     <= 1'b1;
                r_retire_pc  <= next_pc_i;
                r_retire_cnt <= r_retire_cnt + C'(1);
                if (wr_en_i) begin
                    r_wa3 <= rd_i;
                    r_wd3 <= alu_res_i;
                end
            end else if (w_ld_done) begin
                r_we3        <= r_req.wr_en;
                r_retire     <= 1'b1;
                r_retire_pc  <= r_req.next_pc;
                r_retire_cnt <= r_retire_cnt + C'(1);
                if (r_req.wr_en) begin
                    r_wa3 <= r_req.rd;
                    r_wd3 <= mem_rdata_i;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Sticky load-timeout flag
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_err <= 1'b0;
        end else if (w_timeout) begin
            r_err <= 1'b1;
        end
    end

    // Stall is a pure decode of the state register.
    assign stall_o      = (r_state == WAIT_MEM);
    assign we3          = r_we3;
    assign wa3          = r_wa3;
    assign wd3          = r_wd3;
    assign retire_o     = r_retire;
    assign retire_pc_o  = r_retire_pc;
    assign retire_cnt_o = r_retire_cnt;
    assign err_o        = r_err;

endmodule : wb_stage
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_stage
//  Description : Self-checking bench for wb_stage (C=4, TMO=4). Expected
//                writes and retire PCs are queued as stimulus is driven and
//                compared when the DUT pulses we3 / retire_o.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_stage;

    localparam int P   = 16;
    localparam int D   = 16;
    localparam int R   = 4;
    localparam int C   = 4;
    localparam int TMO = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         valid;
    logic         wr_en;
    logic         is_load;
    logic [R-1:0] rd;
    logic [D-1:0] alu_res;
    logic [P-1:0] next_pc;
    logic         mem_ack;
    logic [D-1:0] mem_rdata;
    logic         stall;
    logic         we3;
    logic [R-1:0] wa3;
    logic [D-1:0] wd3;
    logic         retire;
    logic [P-1:0] retire_pc;
    logic [C-1:0] retire_cnt;
    logic         err;

    int n_checks = 0;
    int n_errors = 0;

    logic [R+D-1:0] wr_q[$];
    logic [P-1:0]   pc_q[$];
    logic [C-1:0]   model_cnt = '0;
    int             we3_pulses = 0;
    int             retire_pulses = 0;

    always #5 clk = ~clk;

    wb_stage #(.P(P), .D(D), .R(R), .C(C), .TMO(TMO)) u_dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .valid_i      (valid),
        .wr_en_i      (wr_en),
        .is_load_i    (is_load),
        .rd_i         (rd),
        .alu_res_i    (alu_res),
        .next_pc_i    (next_pc),
        .mem_ack_i    (mem_ack),
        .mem_rdata_i  (mem_rdata),
        .stall_o      (stall),
        .we3          (we3),
        .wa3          (wa3),
        .wd3          (wd3),
        .retire_o     (retire),
        .retire_pc_o  (retire_pc),
        .retire_cnt_o (retire_cnt),
        .err_o        (err)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit
    // after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        valid   = 1'b0;
        wr_en   = 1'b0;
        is_load = 1'b0;
        rd      = '0;
        alu_res = '0;
        next_pc = '0;
        mem_ack = 1'b0;
        mem_rdata = '0;
    endtask

    task automatic drive_alu(input logic w, input logic [R-1:0] r,
                             input logic [D-1:0] d, input logic [P-1:0] pc);
        valid   = 1'b1;
        is_load = 1'b0;
        wr_en   = w;
        rd      = r;
        alu_res = d;
        next_pc = pc;
        if (w) wr_q.push_back({r, d});
        pc_q.push_back(pc);
    endtask

    task automatic drive_load(input logic w, input logic [R-1:0] r, input logic [P-1:0] pc);
        valid   = 1'b1;
        is_load = 1'b1;
        wr_en   = w;
        rd      = r;
        alu_res = 16'hDEAD;
        next_pc = pc;
    endtask

    // Scoreboard: every write/retire pulse must match the head of its queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (we3) begin
                we3_pulses++;
                if (wr_q.size() == 0) begin
                    check_val("we3_unexpected", {31'd0, we3}, 32'd0);
                end else begin
                    logic [R+D-1:0] e;
                    e = wr_q.pop_front();
                    check_val("sb_wa3", {28'd0, wa3}, {28'd0, e[R+D-1:D]});
                    check_val("sb_wd3", {16'd0, wd3}, {16'd0, e[D-1:0]});
                end
            end
            if (retire) begin
                retire_pulses++;
                model_cnt = model_cnt + 1'b1;
                if (pc_q.size() == 0) begin
                    check_val("retire_unexpected", {31'd0, retire}, 32'd0);
                end else begin
                    logic [P-1:0] epc;
                    epc = pc_q.pop_front();
                    check_val("sb_retire_pc", {16'd0, retire_pc}, {16'd0, epc});
                end
                check_val("sb_retire_cnt", {28'd0, retire_cnt}, {28'd0, model_cnt});
            end
        end
    end

    initial begin
        int we3_before;
        int ret_before;

        idle_inputs();
        rst = 1'b1;
        step();
        step();

        // Reset state
        check_val("rst_we3",    {31'd0, we3},    32'd0);
        check_val("rst_retire", {31'd0, retire}, 32'd0);
        check_val("rst_stall",  {31'd0, stall},  32'd0);
        check_val("rst_err",    {31'd0, err},    32'd0);
        check_val("rst_cnt",    {28'd0, retire_cnt}, 32'd0);
        check_val("rst_wa3",    {28'd0, wa3},    32'd0);
        check_val("rst_wd3",    {16'd0, wd3},    32'd0);
        check_val("rst_pc",     {16'd0, retire_pc}, 32'd0);
        rst = 1'b0;
        step();

        // ALU write, 1-cycle latency
        drive_alu(1'b1, 4'd9, 16'h09A9, 16'd42);
        step();
        idle_inputs();
        check_val("alu_we3",    {31'd0, we3},    32'd1);
        check_val("alu_wa3",    {28'd0, wa3},    32'd9);
        check_val("alu_wd3",    {16'd0, wd3},    32'h09A9);
        check_val("alu_retire", {31'd0, retire}, 32'd1);
        check_val("alu_pc",     {16'd0, retire_pc}, 32'd42);
        check_val("alu_cnt",    {28'd0, retire_cnt}, 32'd1);
        step();
        check_val("alu_we3_low", {31'd0, we3}, 32'd0);
        check_val("alu_wa3_hold", {28'd0, wa3}, 32'd9);

        // Load, ack three cycles after accept, non-load accepted on write cycle
        drive_load(1'b1, 4'd5, 16'd69);
        wr_q.push_back({4'd5, 16'h054F});
        pc_q.push_back(16'd69);
        step();
        idle_inputs();
        check_val("ld_stall1", {31'd0, stall}, 32'd1);
        step();
        check_val("ld_stall2", {31'd0, stall}, 32'd1);
        step();
        check_val("ld_stall3", {31'd0, stall}, 32'd1);
        mem_ack   = 1'b1;
        mem_rdata = 16'h054F;
        step();
        idle_inputs();
        check_val("ld_stall_done", {31'd0, stall}, 32'd0);
        check_val("ld_we3", {31'd0, we3}, 32'd1);
        check_val("ld_wa3", {28'd0, wa3}, 32'd5);
        check_val("ld_wd3", {16'd0, wd3}, 32'h054F);
        drive_alu(1'b1, 4'd7, 16'h1234, 16'd70);
        step();
        idle_inputs();
        check_val("post_ld_we3", {31'd0, we3}, 32'd1);
        check_val("post_ld_wa3", {28'd0, wa3}, 32'd7);
        step();

        // Timeout: no ack, stall for TMO cycles then error
        we3_before = we3_pulses;
        ret_before = retire_pulses;
        drive_load(1'b1, 4'd3, 16'd80);
        step();
        idle_inputs();
        for (int i = 0; i < TMO; i++) begin
            check_val($sformatf("tmo_stall%0d", i), {31'd0, stall}, 32'd1);
            step();
        end
        check_val("tmo_stall_end", {31'd0, stall}, 32'd0);
        check_val("tmo_err",       {31'd0, err},   32'd1);
        check_val("tmo_cnt",       {28'd0, retire_cnt}, {28'd0, model_cnt});
        // Ack while idle is ignored
        mem_ack   = 1'b1;
        mem_rdata = 16'hBEEF;
        step();
        idle_inputs();
        step();
        check_val("tmo_no_we3",    we3_pulses,    we3_before);
        check_val("tmo_no_retire", retire_pulses, ret_before);
        check_val("tmo_err_sticky", {31'd0, err}, 32'd1);

        // Back-to-back non-loads
        for (int i = 1; i <= 3; i++) begin
            drive_alu(1'b1, R'(i), D'(i), P'(100 + i));
            step();
        end
        idle_inputs();
        step();
        check_val("b2b_cnt", {28'd0, retire_cnt}, {28'd0, model_cnt});

        // Reset in the same cycle as an ack in WAIT_MEM
        drive_load(1'b1, 4'd6, 16'd90);
        step();
        idle_inputs();
        check_val("rmw_stall", {31'd0, stall}, 32'd1);
        we3_before = we3_pulses;
        rst       = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 16'hAAAA;
        step();
        model_cnt = '0;
        check_val("rmw_stall_after", {31'd0, stall}, 32'd0);
        check_val("rmw_we3",  {31'd0, we3}, 32'd0);
        check_val("rmw_cnt",  {28'd0, retire_cnt}, 32'd0);
        check_val("rmw_err",  {31'd0, err}, 32'd0);
        rst = 1'b0;
        idle_inputs();
        step();
        step();
        check_val("rmw_no_write", we3_pulses, we3_before);

        // Counter wrap: 16 retiring non-writes
        we3_before = we3_pulses;
        ret_before = retire_pulses;
        for (int i = 0; i < 16; i++) begin
            drive_alu(1'b0, R'(i), 16'hFFFF, P'(200 + i));
            step();
        end
        idle_inputs();
        step();
        check_val("wrap_cnt",    {28'd0, retire_cnt}, 32'd0);
        check_val("wrap_we3",    we3_pulses, we3_before);
        check_val("wrap_retire", retire_pulses, ret_before + 16);

        step();
        check_val("wr_q_empty", wr_q.size(), 0);
        check_val("pc_q_empty", pc_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_wb_stage
`default_nettype wire

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage of the 16-bit pipeline: the producer end of the register-file write port (we3/wa3/wd3) that the decode stage consumes.
- Accepts completed instructions from the EX/MEM pipe and registers ALU results.
- For loads, waits on the data-memory acknowledge, stalling upstream meanwhile.
- Drives exactly one register-file write per retired writing instruction, plus retire trace/count outputs.

Parameters:
P, 16, program-counter width
D, 16, data/register width
R, 4, register address width
C, 16, retire counter width
TMO, 15, max cycles to wait for mem_ack_i before abandoning a load (>=1)

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  synchronous, active-high reset
valid_i  in  1  EX/MEM presents an instruction this cycle
wr_en_i  in  1  instruction writes a register
is_load_i  in  1  result comes from data memory, not ALU
rd_i  in  R  destination register
alu_res_i  in  D  ALU result
next_pc_i  in  P  next_pc of the instruction (trace)
mem_ack_i  in  1  data-memory read completes this cycle
mem_rdata_i  in  D  load data, valid with mem_ack_i
stall_o  out  1  upstream must hold; valid_i ignored while high
we3  out  1  register-file write enable (1-cycle pulse)
wa3  out  R  register-file write address
wd3  out  D  register-file write data
retire_o  out  1  1-cycle pulse per retired instruction
retire_pc_o  out  P  next_pc of retiring instruction
retire_cnt_o  out  C  retired-instruction count
err_o  out  1  sticky: a load timed out

Behaviour:
- Interface: one clock clk_i; reset rst_i is synchronous and active-high.
- Reset, sampled on the clock edge:
  - State goes to IDLE.
  - we3, retire_o, stall_o, err_o, retire_cnt_o go to 0.
  - wa3, wd3, retire_pc_o go to 0.
  - Any pending load is discarded with no write.
- FSM has two states: IDLE and WAIT_MEM.
- stall_o = (state == WAIT_MEM), decoded from the register only, with no combinational path from inputs.
- Accept rule: an instruction is accepted when valid_i=1 and stall_o=0.
- Non-load accepted at cycle N:
  - At N+1: retire_o=1, retire_pc_o=next_pc_i, we3=wr_en_i, wa3=rd_i, wd3=alu_res_i.
  - retire_cnt_o increments at N+1.
  - Latency is 1 cycle, and back-to-back accepts retire every cycle.
- Load accepted at cycle N:
  - Go to WAIT_MEM at N+1, latching rd, wr_en and next_pc.
  - The timeout counter loads 0.
- WAIT_MEM with mem_ack_i=1 at cycle M:
  - Capture mem_rdata_i.
  - At M+1: state=IDLE, we3=latched wr_en, wa3=latched rd, wd3=captured data, retire_o=1, counter++.
  - A new valid_i may be accepted at M+1 because stall_o is already 0.
  - The earliest ack is at N+1, giving a minimum load latency of 2 cycles.
- WAIT_MEM without ack: the timeout counter increments each cycle.
  - If the counter reaches TMO-1 with still no ack, go to IDLE next cycle.
  - On that path: no we3, no retire_o, err_o set (sticky until reset).
- mem_ack_i in IDLE is ignored.
- we3, retire_o and wa3/wd3:
  - we3 and retire_o are 0 in every cycle not listed above.
  - wa3/wd3 hold their last value when we3=0.
- A load or non-load with wr_en_i=0 still retires (retire_o=1, counter++) with we3=0.
- All register addresses, including 0, are writable; the register file owns any hardwired-zero policy.
- retire_cnt_o wraps modulo 2^C.
- A reset asserted during WAIT_MEM wins over a simultaneous mem_ack_i.

Decomposition:
- Shared package cpu_pkg:
  - wb_state_t enum {IDLE, WAIT_MEM}.
  - Struct wb_req_t {wr_en, rd, next_pc} used for the latched load context.
  - Widths D/R/P defaults.
- No sub-module. FSM, timeout counter and retire counter all stay in wb_stage.

Test Plan:
- ALU write: valid_i=1, is_load_i=0, wr_en_i=1, rd_i=9, alu_res_i=16'h09A9, next_pc_i=42 at N -> at N+1 we3=1, wa3=9, wd3=16'h09A9, retire_o=1, retire_pc_o=42, retire_cnt_o=1; at N+2 we3=0.
- Load: load rd_i=5, next_pc_i=69; mem_ack_i with mem_rdata_i=16'h054F three cycles later -> stall_o high 3 cycles, then we3=1, wa3=5, wd3=16'h054F for one cycle; a non-load presented that cycle is accepted.
- Timeout, TMO=4: load with no ack -> stall_o high 4 cycles, then IDLE, we3 never 1, retire_cnt_o unchanged, err_o=1 until reset.
- Back-to-back non-loads: rd 1,2,3 with data 1,2,3 on consecutive cycles -> three consecutive we3 pulses with matching wa3/wd3; retire_cnt_o=3.
- Reset mid-wait: rst_i=1 in the same cycle as mem_ack_i in WAIT_MEM -> next cycle stall_o=0, we3=0, retire_cnt_o=0, no write ever issued.
- Counter wrap, C=4: 16 retiring non-loads with wr_en_i=0 -> retire_cnt_o=0, we3 never asserted, retire_o 16 pulses.
